// File: rtl/btn_repeat_encoder_pkg.sv
// Shared game types: button indices, CLK_PLL-derived repeat timing and the
// repeat FSM state type.
package btn_repeat_encoder_pkg;

  localparam int N_BTN         = 5;
  localparam int BTN_IDX_LEFT  = 0;
  localparam int BTN_IDX_DOWN  = 1;
  localparam int BTN_IDX_RIGHT = 2;
  localparam int BTN_IDX_UP    = 3;
  localparam int BTN_IDX_ENTER = 4;

  localparam int unsigned CLK_PLL_HZ           = 500_000;
  localparam int unsigned DEFAULT_DELAY_CYCLES = CLK_PLL_HZ / 2;
  localparam int unsigned DEFAULT_RATE_CYCLES  = CLK_PLL_HZ / 10;

  localparam logic [N_BTN-1:0] DEFAULT_REPEAT_MASK =
    (N_BTN'(1) << BTN_IDX_LEFT) | (N_BTN'(1) << BTN_IDX_DOWN) |
    (N_BTN'(1) << BTN_IDX_RIGHT) | (N_BTN'(1) << BTN_IDX_UP);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } st_BTN_REP_STATE;

  // Lowest set bit wins when several buttons go down in the same cycle.
  function automatic logic [2:0] lowest_idx(input logic [N_BTN-1:0] v);
    lowest_idx = 3'd0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

endpackage

// File: rtl/btn_repeat_encoder_timer.sv
// Loadable down-counter for the repeat schedule; load beats decrement and the
// count parks at zero.
module btn_repeat_timer
  import btn_repeat_encoder_pkg::*;
#(
  parameter int CNT_W = 20
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/btn_repeat_encoder.sv
// Debounced active-low buttons to one-cycle press pulses with typematic
// auto-repeat on the most recently pressed repeatable button.
//
//   state  | meaning
//   IDLE   | nothing tracked; only fresh press pulses
//   DELAY  | tracked button held, waiting for the first repeat
//   REPEAT | tracked button held, repeating at the rate interval
module btn_repeat_encoder
  import btn_repeat_encoder_pkg::*;
#(
  parameter int unsigned      DELAY_CYCLES = DEFAULT_DELAY_CYCLES,
  parameter int unsigned      RATE_CYCLES  = DEFAULT_RATE_CYCLES,
  parameter int               CNT_W        = 20,
  parameter logic [N_BTN-1:0] REPEAT_MASK  = DEFAULT_REPEAT_MASK
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_en,
  input  logic [N_BTN-1:0] i_btn_deb,
  output logic [N_BTN-1:0] o_btn_edge,
  output logic             o_btn_repeat,
  output logic [2:0]       o_held_idx,
  output logic             o_held_valid
);

  localparam logic [CNT_W-1:0] DELAY_LOAD = CNT_W'(DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD  = CNT_W'(RATE_CYCLES - 1);

  st_BTN_REP_STATE  r_state;
  st_BTN_REP_STATE  w_state_nxt;
  logic [N_BTN-1:0] r_prev_lvl;
  logic [N_BTN-1:0] r_btn_edge;
  logic             r_btn_repeat;
  logic [2:0]       r_held_idx;
  logic             r_held_valid;

  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_press_m;
  logic [N_BTN-1:0] w_edge;
  logic             w_rep;
  logic [2:0]       w_idx_nxt;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_tmr_zero;
  logic             w_tracking;
  logic             w_held_rel;

  assign w_press    = r_prev_lvl & ~i_btn_deb;
  assign w_press_m  = w_press & REPEAT_MASK;
  assign w_tracking = (r_state != IDLE);
  assign w_held_rel = i_btn_deb[r_held_idx];

  btn_repeat_timer #(.CNT_W(CNT_W)) u_timer (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_tracking),
    .o_zero     (w_tmr_zero)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_held_idx;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_edge      = w_press;
    w_rep       = 1'b0;
    if (w_press_m != '0) begin
      w_state_nxt = DELAY;
      w_idx_nxt   = lowest_idx(w_press_m);
      w_load      = 1'b1;
      w_load_val  = DELAY_LOAD;
    end else if (w_tracking) begin
      if (w_held_rel) begin
        w_state_nxt = IDLE;
      end else if (w_tmr_zero) begin
        // Schedule keeps running even when a fresh ENTER press steals the slot.
        w_state_nxt = REPEAT;
        w_load      = 1'b1;
        w_load_val  = RATE_LOAD;
        if (w_press == '0) begin
          w_edge[r_held_idx] = 1'b1;
          w_rep              = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    r_prev_lvl <= i_btn_deb;
    if (i_reset) begin
      r_state      <= IDLE;
      r_btn_edge   <= '0;
      r_btn_repeat <= 1'b0;
      r_held_idx   <= 3'd0;
      r_held_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_btn_edge   <= i_en ? w_edge : '0;
      r_btn_repeat <= i_en & w_rep;
      r_held_idx   <= w_idx_nxt;
      r_held_valid <= (w_state_nxt != IDLE);
    end
  end

  assign o_btn_edge   = r_btn_edge;
  assign o_btn_repeat = r_btn_repeat;
  assign o_held_idx   = r_held_idx;
  assign o_held_valid = r_held_valid;

endmodule

// File: tb/tb_btn_repeat_encoder.sv
// Scoreboard bench for btn_repeat_encoder: a timestamp-based reference model
// queues the expected outputs for every driven cycle.
module tb_btn_repeat_encoder;

  localparam int D = 8;
  localparam int R = 3;
  localparam logic [4:0] MASK = 5'b01111;
  localparam logic [4:0] NONE = 5'b11111;

  logic       clk = 1'b0;
  logic       i_reset = 1'b1;
  logic       i_en = 1'b1;
  logic [4:0] i_btn_deb = NONE;
  logic [4:0] o_btn_edge;
  logic       o_btn_repeat;
  logic [2:0] o_held_idx;
  logic       o_held_valid;

  typedef struct packed {
    logic [4:0] edg;
    logic       rep;
    logic       valid;
    logic [2:0] idx;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_enter = 0;

  logic [4:0] m_prev;
  logic       m_valid = 1'b0;
  logic [2:0] m_idx = 3'd0;
  int         m_t0 = 0;
  int         m_cyc = 0;

  always #5 clk = ~clk;

  btn_repeat_encoder #(
    .DELAY_CYCLES (D),
    .RATE_CYCLES  (R),
    .CNT_W        (4),
    .REPEAT_MASK  (MASK)
  ) dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_en         (i_en),
    .i_btn_deb    (i_btn_deb),
    .o_btn_edge   (o_btn_edge),
    .o_btn_repeat (o_btn_repeat),
    .o_held_idx   (o_held_idx),
    .o_held_valid (o_held_valid)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", tag, m_cyc, got, exp);
    end
  endtask

  // Drive one cycle of inputs, queue the model's view of the next outputs,
  // then compare once the DUT has registered them.
  task automatic step(input logic rst, input logic en, input logic [4:0] btn);
    exp_t       e;
    logic [4:0] press;
    logic [4:0] pm;
    int         k;
    @(negedge clk);
    i_reset   = rst;
    i_en      = en;
    i_btn_deb = btn;
    e = '0;
    if (rst) begin
      m_valid = 1'b0;
      m_idx   = 3'd0;
    end else begin
      press = m_prev & ~btn;
      pm    = press & MASK;
      e.edg = press;
      if (pm != 5'd0) begin
        for (int i = 4; i >= 0; i--) if (pm[i]) m_idx = 3'(i);
        m_valid = 1'b1;
        m_t0    = m_cyc + 1;
      end else if (m_valid) begin
        if (btn[m_idx]) begin
          m_valid = 1'b0;
        end else begin
          k = m_cyc + 1 - m_t0;
          if (k >= D && ((k - D) % R) == 0 && press == 5'd0) begin
            e.edg[m_idx] = 1'b1;
            e.rep        = 1'b1;
          end
        end
      end
      if (!en) begin
        e.edg = 5'd0;
        e.rep = 1'b0;
      end
    end
    e.valid = m_valid;
    e.idx   = m_idx;
    m_prev  = btn;
    q.push_back(e);
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk("btn_edge",   8'(o_btn_edge),   8'(e.edg));
    chk("btn_repeat", 8'(o_btn_repeat), 8'(e.rep));
    chk("held_valid", 8'(o_held_valid), 8'(e.valid));
    chk("held_idx",   8'(o_held_idx),   8'(e.idx));
    if (o_btn_edge[4]) n_enter++;
    m_cyc++;
  endtask

  task automatic run(input int n, input logic en, input logic [4:0] btn);
    for (int j = 0; j < n; j++) step(1'b0, en, btn);
  endtask

  initial begin
    // reset with nothing pressed
    step(1'b1, 1'b1, NONE);
    step(1'b1, 1'b1, NONE);
    run(4, 1'b1, NONE);

    // UP held for 20 cycles: fresh + four repeats, then release
    run(20, 1'b1, 5'b10111);
    run(6, 1'b1, NONE);

    // ENTER held 40 cycles: single pulse, never tracked
    n_enter = 0;
    run(40, 1'b1, 5'b01111);
    chk("enter_pulses", 8'(n_enter), 8'd1);
    run(4, 1'b1, NONE);

    // LEFT, then RIGHT four cycles later: tracking moves to RIGHT
    run(4, 1'b1, 5'b11110);
    run(16, 1'b1, 5'b11010);
    run(4, 1'b1, NONE);

    // LEFT and DOWN together: both pulse, LEFT tracked
    run(12, 1'b1, 5'b11100);
    run(4, 1'b1, NONE);

    // DOWN held across a mid-tracking reset: silent until re-pressed
    run(6, 1'b1, 5'b11101);
    step(1'b1, 1'b1, 5'b11101);
    step(1'b1, 1'b1, 5'b11101);
    run(12, 1'b1, 5'b11101);
    run(5, 1'b1, NONE);
    run(5, 1'b1, 5'b11101);
    run(3, 1'b1, NONE);

    // UP held while EN drops over repeat points, schedule unchanged afterwards
    run(10, 1'b1, 5'b10111);
    run(8, 1'b0, 5'b10111);
    run(10, 1'b1, 5'b10111);
    run(3, 1'b1, NONE);

    // ENTER press lands on a repeat slot, then ENTER release is ignored
    run(8, 1'b1, 5'b10111);
    run(6, 1'b1, 5'b00111);
    run(6, 1'b1, 5'b10111);
    run(4, 1'b1, NONE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
